// File: rtl/msrv32_fetch_flush_ctrl_if.sv
// rtl/msrv32_fetch_flush_ctrl_if.sv - fetch sequencer memory, redirect and mux signal bundle
interface msrv32_fetch_flush_ctrl_if #(
  parameter int CNT_W = 16
);
  logic              ms_riscv32_mp_instr_hready_in;
  logic [31:0]       ms_riscv32_mp_instr_in;
  logic              branch_taken_in;
  logic              trap_taken_in;
  logic              stall_in;
  logic              flush_out;
  logic [31:0]       instr_out;
  logic              instr_req_out;
  logic              pc_en_out;
  logic              instr_valid_out;
  logic [CNT_W-1:0]  flush_count_out;

  modport master (
    input  ms_riscv32_mp_instr_hready_in, ms_riscv32_mp_instr_in,
    input  branch_taken_in, trap_taken_in, stall_in,
    output flush_out, instr_out, instr_req_out, pc_en_out,
    output instr_valid_out, flush_count_out
  );

  modport slave (
    output ms_riscv32_mp_instr_hready_in, ms_riscv32_mp_instr_in,
    output branch_taken_in, trap_taken_in, stall_in,
    input  flush_out, instr_out, instr_req_out, pc_en_out,
    input  instr_valid_out, flush_count_out
  );
endinterface

// File: rtl/msrv32_fetch_flush_ctrl.sv
// rtl/msrv32_fetch_flush_ctrl.sv - instruction fetch sequencer with flush bubbles and stall hold
module msrv32_fetch_flush_ctrl #(
  parameter int RESET_FLUSH  = 2,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                      ms_riscv32_mp_clk_in,
  input  logic                      ms_riscv32_mp_rst_in,
  msrv32_fetch_flush_ctrl_if.master bus
);
  localparam int MAX_C  = (RESET_FLUSH > FLUSH_CYCLES) ? RESET_FLUSH : FLUSH_CYCLES;
  localparam int CW_RAW = $clog2(MAX_C + 1);
  localparam int CW     = (CW_RAW > 3) ? CW_RAW : 3;
  localparam logic [CW-1:0] RST_LOAD   = CW'(RESET_FLUSH - 1);
  localparam logic [CW-1:0] REDIR_LOAD = CW'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);
  localparam logic [31:0]   NOP        = 32'h0000_0013;

  typedef enum logic [1:0] {ST_RST, ST_FETCH, ST_HOLD, ST_REDIR} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [31:0]      hold_reg;
  logic [CNT_W-1:0] flush_count;
  logic             redirect;
  logic             flush;
  logic             req;
  logic             pc_en;

  assign redirect = bus.branch_taken_in | bus.trap_taken_in;

  always_comb begin
    flush = 1'b0;
    req   = 1'b0;
    pc_en = 1'b0;
    case (state)
      ST_RST:   flush = 1'b1;
      ST_FETCH: begin
        req   = 1'b1;
        flush = ~bus.ms_riscv32_mp_instr_hready_in;
        pc_en = bus.ms_riscv32_mp_instr_hready_in & ~bus.stall_in;
      end
      ST_HOLD:  pc_en = ~bus.stall_in;
      ST_REDIR: begin
        req   = 1'b1;
        flush = 1'b1;
      end
      default:  flush = 1'b1;
    endcase
    // Redirect overrides stall and hready: the PC must load the target now.
    if (state != ST_RST && redirect) begin
      flush = 1'b1;
      pc_en = 1'b1;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state       <= ST_RST;
      cnt         <= RST_LOAD;
      hold_reg    <= NOP;
      flush_count <= '0;
    end else begin
      if (flush && flush_count != '1)
        flush_count <= flush_count + CNT_W'(1);
      if (state == ST_RST) begin
        if (cnt == '0) state <= ST_FETCH;
        else           cnt   <= cnt - CW'(1);
      end else if (redirect) begin
        hold_reg <= NOP;
        cnt      <= REDIR_LOAD;
        state    <= (FLUSH_CYCLES == 0) ? ST_FETCH : ST_REDIR;
      end else begin
        case (state)
          ST_FETCH: if (bus.ms_riscv32_mp_instr_hready_in && bus.stall_in) begin
            hold_reg <= bus.ms_riscv32_mp_instr_in;
            state    <= ST_HOLD;
          end
          ST_HOLD:  if (!bus.stall_in) state <= ST_FETCH;
          ST_REDIR: begin
            if (cnt == '0) state <= ST_FETCH;
            else           cnt   <= cnt - CW'(1);
          end
          default:  state <= ST_RST;
        endcase
      end
    end
  end

  assign bus.flush_out       = flush;
  assign bus.instr_req_out   = req;
  assign bus.pc_en_out       = pc_en;
  assign bus.instr_valid_out = ~flush;
  assign bus.flush_count_out = flush_count;
  assign bus.instr_out       = (state == ST_HOLD || state == ST_RST) ? hold_reg
                                                                     : bus.ms_riscv32_mp_instr_in;
endmodule

// File: doc/msrv32_fetch_flush_ctrl.md
# msrv32_fetch_flush_ctrl

Instruction-fetch sequencer for the msrv32 core front end. It drives the instruction mux's flush input, holds the fetched instruction across downstream stalls, and turns branch/trap redirects and instruction-memory wait states into NOP bubbles. It also generates the PC-advance enable and keeps a saturating count of bubble cycles for performance monitoring. It sits between the instruction memory port, the PC generator and the instruction mux.

## Interface
Parameters:
- RESET_FLUSH, 2 — flush cycles issued after reset release (≥1)
- FLUSH_CYCLES, 1 — extra flush cycles after a redirect (0..7)
- CNT_W, 16 — width of the bubble counter

Ports:
- ms_riscv32_mp_clk_in  input  1  core clock
- ms_riscv32_mp_rst_in  input  1  reset, synchronous, active-low
- ms_riscv32_mp_instr_hready_in  input  1  instruction memory data valid this cycle
- ms_riscv32_mp_instr_in  input  32  raw instruction from memory
- branch_taken_in  input  1  branch/jump redirect request
- trap_taken_in  input  1  trap/mret redirect request
- stall_in  input  1  downstream stall (e.g. data memory wait)
- flush_out  output  1  to instruction mux flush input
- instr_out  output  32  instruction to instruction mux
- instr_req_out  output  1  fetch request to instruction memory
- pc_en_out  output  1  PC generator update enable
- instr_valid_out  output  1  decode holds a real instruction
- flush_count_out  output  CNT_W  saturating count of flush cycles

## Operation
- redirect = branch_taken_in | trap_taken_in. Both have identical effect; no priority between them is needed.
- States: RST, FETCH, HOLD, REDIR. A down-counter `cnt` (3 bits min, sized for max(RESET_FLUSH, FLUSH_CYCLES)) serves RST and REDIR.
- RST (entered on reset; cnt = RESET_FLUSH-1):
  - flush_out=1, instr_req_out=0, pc_en_out=0.
  - Redirects are ignored.
  - cnt==0 → FETCH; otherwise decrement.
- FETCH: instr_req_out=1.
  - hready=0: flush_out=1, pc_en_out=0; stay in FETCH.
  - hready=1, stall=0: flush_out=0, pc_en_out=1; stay in FETCH.
  - hready=1, stall=1: capture instr_in into hold_reg, pc_en_out=0 → HOLD.
- HOLD:
  - instr_out=hold_reg, flush_out=0, instr_req_out=0.
  - stall=0: pc_en_out=1 → FETCH.
  - stall=1: pc_en_out=0; stay in HOLD.
- REDIR:
  - flush_out=1, instr_req_out=1; hready data is discarded; pc_en_out=0.
  - cnt==0 → FETCH; otherwise decrement.
- Redirect in FETCH/HOLD/REDIR, highest priority (beats stall and hready):
  - Same cycle: flush_out=1, pc_en_out=1 (PC loads target); hold_reg is discarded.
  - Next state: REDIR with cnt=FLUSH_CYCLES-1, or FETCH if FLUSH_CYCLES=0.
  - A redirect while in REDIR restarts the count.
- instr_out = hold_reg in HOLD, else ms_riscv32_mp_instr_in (passthrough).
- instr_valid_out = ~flush_out.
- flush_count_out increments by 1 on every cycle with flush_out=1 and saturates at all-ones; it never wraps.

## Timing
- Reset (rst_in=0 at a clock edge):
  - Next cycle: state=RST, flush_out=1, instr_req_out=0, pc_en_out=0, instr_valid_out=0, hold_reg=32'h00000013, flush_count_out=0.
  - instr_out=hold_reg reset value (NOP) during RST.
- Reset asserted mid-operation (any state, including mid-HOLD or mid-REDIR) behaves identically to power-on: the counter and hold_reg are cleared.
- After reset release: exactly RESET_FLUSH flush cycles, then the first FETCH cycle with instr_req_out=1.
- All outputs are combinational from the registered state and current-cycle inputs. State, cnt, hold_reg and flush_count_out are registered.
- Redirect cost: 1 + FLUSH_CYCLES flush cycles before fetch resumes.
- Stall costs no flush cycles. The held instruction is presented continuously, with flush_out=0, until stall drops.
- The flush counter counts reset bubbles, redirect bubbles and memory wait bubbles.

## Test plan
- Reset with RESET_FLUSH=2, then release with hready=1 → flush_out=1 for 2 cycles, then instr_out follows memory, pc_en_out=1, flush_count_out=2.
- In FETCH, present 32'h00500093 with stall_in=1 for 3 cycles, and change instr_in to 32'hDEADBEEF during the stall → instr_out stays 32'h00500093, pc_en_out=0 for 3 cycles, then 1 when stall drops.
- branch_taken_in pulse for 1 cycle in FETCH with FLUSH_CYCLES=1 → flush_out=1 for 2 cycles, pc_en_out=1 only in the pulse cycle, and hready data in the REDIR cycle is ignored.
- trap_taken_in and stall_in both high while in HOLD → redirect wins: pc_en_out=1, hold_reg is discarded, next state REDIR.
- Redirect in the last REDIR cycle → REDIR restarts; 1+FLUSH_CYCLES further flush cycles follow.
- CNT_W=4 with hready=0 held for 20 cycles → flush_count_out saturates at 4'hF.
